// File: rtl/piezo_tune_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | piezo_tune_sched: arbitrates fanfare / battery / bump tunes, feeds notes.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module piezo_tune_sched #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fanfare_req,
  input  logic        bump_req,
  input  logic        batt_low,
  input  logic        note_rdy,
  input  logic        note_done,
  output logic        note_vld,
  output logic [13:0] note_per,
  output logic [24:0] note_dur,
  output logic        busy,
  output logic [1:0]  tune_id
);

  localparam int          SH  = FAST_SIM ? 8 : 0;
  localparam logic [13:0] G6  = 14'd15944;
  localparam logic [13:0] C7  = 14'd11944;
  localparam logic [13:0] E7  = 14'd9480;
  localparam logic [13:0] G7  = 14'd7971;
  localparam logic [24:0] D21 = 25'h020_0000;
  localparam logic [24:0] D22 = 25'h040_0000;
  localparam logic [24:0] D23 = 25'h080_0000;
  localparam logic [24:0] D24 = 25'h100_0000;
  localparam logic [24:0] D23P22 = D23 + D22;
  localparam logic [24:0] GAP = D24 >> SH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_PLAY  = 3'd2,
    S_NEXT  = 3'd3,
    S_REST  = 3'd4
  } state_t;

  function automatic logic [38:0] note_lut(input logic [1:0] t, input logic [2:0] i);
    logic [38:0] r;
    case ({t, i})
      5'b01_000: r = {G6, D23};
      5'b01_001: r = {C7, D23};
      5'b01_010: r = {E7, D23P22};
      5'b01_011: r = {G7, D22};
      5'b01_100: r = {E7, D23};
      5'b01_101: r = {G7, D24};
      5'b10_000: r = {G6, D23};
      5'b10_001: r = {C7, D23};
      5'b10_010: r = {E7, D23P22};
      5'b11_000: r = {G7, D21};
      default:   r = '0;
    endcase
    return {r[38:25], r[24:0] >> SH};
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] t);
    case (t)
      2'd1:    return 3'd5;
      2'd2:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [1:0]  tune_n, sel;
  logic        fan_p, fan_n, bump_p, bump_n;
  logic        vld_n, start;
  logic [13:0] per_n;
  logic [24:0] dur_n, rest_cnt, rest_n;
  logic [38:0] lut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      tune_id  <= '0;
      fan_p    <= 1'b0;
      bump_p   <= 1'b0;
      note_vld <= 1'b0;
      note_per <= '0;
      note_dur <= '0;
      rest_cnt <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      tune_id  <= tune_n;
      fan_p    <= fan_n;
      bump_p   <= bump_n;
      note_vld <= vld_n;
      note_per <= per_n;
      note_dur <= dur_n;
      rest_cnt <= rest_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tune_n  = tune_id;
    fan_n   = fan_p;
    bump_n  = bump_p;
    per_n   = note_per;
    dur_n   = note_dur;
    rest_n  = rest_cnt;
    start   = 1'b0;
    sel     = fan_p ? 2'd1 : batt_low ? 2'd2 : bump_p ? 2'd3 : 2'd0;

    case (state)
      S_IDLE: begin
        start = (sel != 2'd0);
      end
      S_ISSUE: begin
        if (note_rdy) state_n = S_PLAY;
      end
      S_PLAY: begin
        if (note_done) state_n = S_NEXT;
      end
      S_NEXT: begin
        if (idx != last_idx(tune_id)) begin
          idx_n   = idx + 3'd1;
          state_n = S_ISSUE;
        end else if (tune_id == 2'd2 && batt_low) begin
          rest_n  = GAP;
          state_n = S_REST;
        end else begin
          start   = (sel != 2'd0);
          state_n = S_IDLE;
          tune_n  = 2'd0;
        end
      end
      S_REST: begin
        // Counter is preloaded with GAP, so exiting at 1 spends exactly GAP cycles here.
        if (fan_p || !batt_low || rest_cnt <= 25'd1) begin
          state_n = S_IDLE;
          tune_n  = 2'd0;
          rest_n  = '0;
        end else begin
          rest_n = rest_cnt - 25'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        tune_n  = 2'd0;
      end
    endcase

    if (start) begin
      state_n = S_ISSUE;
      tune_n  = sel;
      idx_n   = 3'd0;
      if (sel == 2'd1) fan_n = 1'b0;
      if (sel == 2'd3) bump_n = 1'b0;
    end

    // A request arriving on a start edge is kept rather than lost.
    if (fanfare_req) fan_n = 1'b1;
    if (bump_req) bump_n = 1'b1;

    vld_n = (state_n == S_ISSUE);
    lut   = note_lut(tune_n, idx_n);
    if (state_n == S_ISSUE && state != S_ISSUE) begin
      per_n = lut[38:25];
      dur_n = lut[24:0];
    end
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire
